// File: rtl/tx_info_pkg.sv
// Shared constants, field/state encodings and checksum helper for the info-frame builder.
// crc8_byte is compiled only when TX_INFO_FRM_CRC8_EN is defined.
package tx_info_pkg;

    localparam logic [7:0] HDR0_DEF  = 8'hA5;
    localparam logic [7:0] HDR1_DEF  = 8'h5A;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {F_HDR0, F_HDR1, F_LEN, F_PAY, F_CHK} field_t;
    typedef enum logic [2:0] {S_IDLE, S_FIRE, S_WAIT, S_GAP, S_DONE} state_t;

`ifdef TX_INFO_FRM_CRC8_EN
    // MSB-first CRC-8, one full byte per call.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        return c;
    endfunction
`endif

endpackage

// File: rtl/tx_info_fifo.sv
// Synchronous DEPTHx8 payload FIFO; head byte is visible on rd_data before it is popped.
module tx_info_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk_sys,
    input  logic                       rst_n,
    input  logic                       wr,
    input  logic [7:0]                 wr_data,
    input  logic                       rd,
    output logic [7:0]                 rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_wr, do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr && !full;
    assign do_rd   = rd && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_sys)
        if (do_wr) mem[wr_ptr] <= wr_data;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tx_info_frm.sv
// Info-frame builder: HDR0, HDR1, LEN, payload, CHK to a byte-serial PHY, one byte per fire/done.
// Define TX_INFO_FRM_CRC8_EN to make CHK a CRC-8 instead of the additive sum.
module tx_info_frm
    import tx_info_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter logic [7:0] HDR0    = HDR0_DEF,
    parameter logic [7:0] HDR1    = HDR1_DEF,
    parameter int         GAP_CYC = 0
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    input  logic       start_frm,
    output logic       busy,
    output logic       frm_done,
    output logic       wr_err,
    output logic       fire_tx,
    output logic [7:0] data_tx,
    input  logic       done_tx
);

    localparam int AW = $clog2(DEPTH);

    state_t        state, state_nxt;
    field_t        fld, fld_nxt;
    logic [7:0]    len, pcnt, pcnt_nxt, chk, gap_cnt, byte_nxt, head;
    logic [AW:0]   count;
    logic          empty, start_acc, wr_acc, pop;

    function automatic logic [7:0] chk_next(input logic [7:0] c, input logic [7:0] d);
`ifdef TX_INFO_FRM_CRC8_EN
        return crc8_byte(c, d);
`else
        return c + d;
`endif
    endfunction

    assign busy      = (state != S_IDLE);
    assign fire_tx   = (state == S_FIRE);
    assign frm_done  = (state == S_DONE);
    assign start_acc = start_frm && !busy;
    assign wr_acc    = wr_en && !busy && !full && !start_frm;
    assign pop       = fire_tx && (fld == F_PAY) && !empty;

    tx_info_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .wr      (wr_acc),
        .wr_data (wr_data),
        .rd      (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_comb begin
        state_nxt = state;
        fld_nxt   = fld;
        pcnt_nxt  = pcnt;
        case (state)
            S_IDLE: if (start_acc) begin
                state_nxt = S_FIRE;
                fld_nxt   = F_HDR0;
                pcnt_nxt  = '0;
            end
            S_FIRE: begin
                state_nxt = S_WAIT;
                if (fld == F_PAY) pcnt_nxt = pcnt + 1'b1;
            end
            S_WAIT: if (done_tx) begin
                if (fld == F_CHK) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = (GAP_CYC == 0) ? S_FIRE : S_GAP;
                    case (fld)
                        F_HDR0:  fld_nxt = F_HDR1;
                        F_HDR1:  fld_nxt = F_LEN;
                        F_LEN:   fld_nxt = (len == '0) ? F_CHK : F_PAY;
                        default: fld_nxt = (pcnt == len) ? F_CHK : F_PAY;
                    endcase
                end
            end
            S_GAP:  if (gap_cnt == 8'(GAP_CYC - 1)) state_nxt = S_FIRE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte for the field about to be fired; chk is already final by the time CHK is reached.
    always_comb begin
        byte_nxt = '0;
        case (fld_nxt)
            F_HDR0:  byte_nxt = HDR0;
            F_HDR1:  byte_nxt = HDR1;
            F_LEN:   byte_nxt = len;
            F_PAY:   byte_nxt = head;
            F_CHK:   byte_nxt = chk;
            default: byte_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            fld     <= F_HDR0;
            pcnt    <= '0;
            len     <= '0;
            chk     <= '0;
            gap_cnt <= '0;
            data_tx <= '0;
            wr_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            fld     <= fld_nxt;
            pcnt    <= pcnt_nxt;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
            if (start_acc) begin
                len    <= 8'(count);
                chk    <= '0;
                wr_err <= 1'b0;
            end
            if (wr_en && !wr_acc) wr_err <= 1'b1;
            if (fire_tx && (fld == F_LEN || fld == F_PAY))
                chk <= chk_next(chk, data_tx);
            if (state_nxt == S_FIRE) data_tx <= byte_nxt;
        end
    end

endmodule

// File: tb/tb_tx_info_frm.sv
// Directed bench for tx_info_frm with a fixed-latency PHY model (DEPTH=16, GAP_CYC=3).
module tb_tx_info_frm;

    localparam int GAP   = 3;
    localparam int PHY_N = 3;

    logic       clk_sys = 1'b0, rst_n = 1'b0;
    logic       wr_en = 1'b0, start_frm = 1'b0, stray_done = 1'b0, phy_done = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, busy, frm_done, wr_err, fire_tx, done_tx;
    logic [7:0] data_tx;

    assign done_tx = phy_done | stray_done;

    tx_info_frm #(.DEPTH(16), .GAP_CYC(GAP)) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .start_frm (start_frm),
        .busy      (busy),
        .frm_done  (frm_done),
        .wr_err    (wr_err),
        .fire_tx   (fire_tx),
        .data_tx   (data_tx),
        .done_tx   (done_tx)
    );

    always #5 clk_sys = ~clk_sys;

    // PHY model: captures each fired byte, answers PHY_N cycles later, flags overlap and gap errors.
    int         cyc = 0, phy_cnt = 0, fire_cnt = 0, frm_cnt = 0, ovl = 0, gap_bad = 0, last_done = 0;
    logic       phy_busy = 1'b0, have_done = 1'b0;
    logic [7:0] rx_q [$];

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            phy_busy  <= 1'b0;
            phy_done  <= 1'b0;
            have_done <= 1'b0;
            phy_cnt   <= 0;
        end else begin
            cyc      <= cyc + 1;
            phy_done <= 1'b0;
            if (frm_done) begin
                frm_cnt   <= frm_cnt + 1;
                have_done <= 1'b0;
            end
            if (phy_done) begin
                last_done <= cyc;
                have_done <= 1'b1;
            end
            if (phy_busy) begin
                if (phy_cnt == 1) begin
                    phy_done <= 1'b1;
                    phy_busy <= 1'b0;
                end else begin
                    phy_cnt <= phy_cnt - 1;
                end
            end
            if (fire_tx) begin
                if (phy_busy) ovl <= ovl + 1;
                if (have_done && (cyc - last_done != GAP + 1)) gap_bad <= gap_bad + 1;
                have_done <= 1'b0;
                rx_q.push_back(data_tx);
                fire_cnt <= fire_cnt + 1;
                phy_busy <= 1'b1;
                phy_cnt  <= PHY_N;
            end
        end
    end

    int n_run = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         n;
        logic [7:0] base;
        logic [7:0] len;
        logic [7:0] chk;
        logic       full;
        logic       werr;
        logic       inject;
    } vec_t;

`ifdef TX_INFO_FRM_CRC8_EN
    function automatic logic [7:0] crc_b(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    function automatic logic [7:0] tb_crc(input vec_t v);
        logic [7:0] c;
        c = crc_b(8'h00, v.len);
        for (int k = 0; k < int'(v.len); k++) c = crc_b(c, v.base + 8'(k));
        return c;
    endfunction
`endif

    task automatic run_frame(input vec_t v, input string tag);
        int q0, f0, g0, o0, tot;
        logic [7:0] e;
        q0 = rx_q.size(); f0 = frm_cnt; g0 = gap_bad; o0 = ovl;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk_sys); wr_en = 1'b1; wr_data = v.base + 8'(i);
        end
        @(negedge clk_sys); wr_en = 1'b0;
        check({tag, " full"}, full, v.full);
        check({tag, " wr_err_pre"}, wr_err, v.werr);
        start_frm = 1'b1;
        @(negedge clk_sys); start_frm = 1'b0;
        check({tag, " busy_start"}, busy, 1'b1);
        check({tag, " fire_first"}, fire_tx, 1'b1);
        check({tag, " hdr0_first"}, data_tx, 8'hA5);
        check({tag, " wr_err_clr"}, wr_err, 1'b0);
        if (v.inject) begin
            repeat (8) @(negedge clk_sys);
            wr_en = 1'b1; wr_data = 8'h77;
            @(negedge clk_sys); wr_en = 1'b0;
            repeat (3) @(negedge clk_sys);
            start_frm = 1'b1;
            @(negedge clk_sys); start_frm = 1'b0;
        end
        for (int c = 0; c < 1000 && frm_cnt == f0; c++) @(negedge clk_sys);
        check({tag, " frm_timeout"}, frm_cnt != f0, 1'b1);
        repeat (6) @(negedge clk_sys);
        check({tag, " frm_done_cnt"}, frm_cnt - f0, 1);
        check({tag, " busy_end"}, busy, 1'b0);
        check({tag, " wr_err_post"}, wr_err, v.inject);
        check({tag, " gap"}, gap_bad - g0, 0);
        check({tag, " phy_overlap"}, ovl - o0, 0);
        tot = int'(v.len) + 4;
        check({tag, " nbytes"}, rx_q.size() - q0, tot);
        for (int j = 0; j < tot && q0 + j < rx_q.size(); j++) begin
            if (j == 0)            e = 8'hA5;
            else if (j == 1)       e = 8'h5A;
            else if (j == 2)       e = v.len;
            else if (j == tot - 1) e = v.chk;
            else                   e = v.base + 8'(j - 3);
            check($sformatf("%s byte%0d", tag, j), rx_q[q0 + j], e);
        end
    endtask

    vec_t tbl [6];
    vec_t zero_v;

    initial begin
        int f0, q0;
        logic found;
        tbl[0] = '{3,  8'h01, 8'h03, 8'h09, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{0,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{17, 8'h01, 8'h10, 8'h98, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{4,  8'hF0, 8'h04, 8'hCA, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2,  8'hAA, 8'h02, 8'h57, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{0,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
`ifdef TX_INFO_FRM_CRC8_EN
        tbl[0].chk = 8'h72;
        for (int i = 1; i < 6; i++) tbl[i].chk = tb_crc(tbl[i]);
`endif
        zero_v = '{0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk_sys);
        check("rst fire_tx", fire_tx, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst full", full, 1'b0);
        check("rst frm_done", frm_done, 1'b0);
        check("rst wr_err", wr_err, 1'b0);
        check("rst data_tx", data_tx, 8'h00);
        rst_n = 1'b1;
        @(negedge clk_sys);

        // done_tx while idle must not provoke a byte
        f0 = fire_cnt;
        stray_done = 1'b1;
        @(negedge clk_sys); stray_done = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("stray_done no fire", fire_cnt - f0, 0);
        check("stray_done busy", busy, 1'b0);

        for (int i = 0; i < 6; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of the payload
        q0 = rx_q.size();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_sys); wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
        end
        @(negedge clk_sys); wr_en = 1'b0;
        start_frm = 1'b1;
        @(negedge clk_sys); start_frm = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk_sys);
            if (fire_tx && rx_q.size() - q0 == 3) found = 1'b1;
        end
        check("midrst reached PAY", found, 1'b1);
        check("midrst full before", full, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst fire_tx", fire_tx, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst full", full, 1'b0);
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        run_frame(zero_v, "postrst");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
